chmem_arbiter: RTL and testbench
================================

# chmem_arbiter

Single-port arbiter for the character/text memory that feeds the video controller's line fetch. The video fetch path has absolute priority and a fixed, stall-free latency. Host accesses (CPU or debug loader writing `mem[]`, reading back) are buffered in a small ordered FIFO and serviced in cycles the video path leaves idle. The block sits between the video timing/fetch logic and the synchronous RAM primitive, in the pixel clock domain.

## Interface
Parameters:
- `AW`, 11, RAM address width
- `DW`, 8, RAM data width
- `FIFO_DEPTH`, 4, host request FIFO entries (power of two, ≥2)
- `STARVE_LIM`, 64, consecutive unserviced cycles before `host_starve` asserts

Ports:
- `pixclk`  in  1  pixel clock; the only clock
- `act_reset`  in  1  asynchronous, active-high reset
- `vid_req`  in  1  video fetch request this cycle
- `vid_addr`  in  AW  video fetch address
- `vid_valid`  out  1  `vid_data` valid (one-cycle pulse per request)
- `vid_data`  out  DW  fetched character code
- `host_valid`  in  1  host request offered
- `host_ready`  out  1  FIFO can accept
- `host_we`  in  1  1 = write, 0 = read
- `host_addr`  in  AW  host address
- `host_wdata`  in  DW  host write data
- `host_rvalid`  out  1  `host_rdata` valid
- `host_rdata`  out  DW  host read data
- `host_starve`  out  1  head of FIFO waited ≥ `STARVE_LIM` cycles
- `ram_en`, `ram_we`  out  1  RAM port enable / write enable
- `ram_addr`  out  AW  RAM address
- `ram_wdata`  out  DW  RAM write data
- `ram_rdata`  in  DW  RAM read data, valid one cycle after `ram_en`

## Operation
- Host handshake: an entry is pushed when `host_valid && host_ready`. `host_ready = !full`. It is not raised by a same-cycle pop.
- FIFO entry is `{we, addr, wdata}`. Reads and writes share one FIFO, so host order is preserved. A read after a write to the same address returns the new data.
- Grant decision each cycle, combinational:
  - `vid_req` → G_VID.
  - Otherwise, FIFO non-empty → G_HOST, and the head is popped.
  - Otherwise → G_NONE.
- The grant and command are registered onto `ram_*`. Only G_VID and G_HOST assert `ram_en`. `ram_we = 1` only for a host write.
- Return path: a 2-stage tag pipeline (`none/vid/host_rd`) tracks the in-flight read. The tag selects whether `ram_rdata` is captured into `vid_data`/`vid_valid` or `host_rdata`/`host_rvalid`. Host writes produce no return.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and grant is G_VID.
  - Clears on any G_HOST or when the FIFO is empty.
  - Saturates at 255.
  - `host_starve = (cnt >= STARVE_LIM)`.
  - The counter is status only and never preempts video.
- Addresses are passed through unmodified; no wrap arithmetic inside the block.

## Timing
- Reset value of every output is 0, including `host_ready`. `host_ready` rises the first cycle after `act_reset` deasserts.
- Reset flushes the FIFO, the tag pipeline and the starvation counter. In-flight reads are dropped, and no `*_rvalid` is issued for them.
- Video: `vid_req` at cycle C → `ram_en` at C+1 → `vid_valid` at C+3. Back-to-back requests give back-to-back `vid_valid`.
- Host: accepted at N → earliest grant N+1 → `ram_en`/`ram_we` at N+2 → read `host_rvalid` at N+4. Host reads are not bypassed around the FIFO.
- Continuous `vid_req` stalls the host indefinitely. Once the FIFO is full, `host_ready` stays low.
- Simultaneous push and pop on a non-full FIFO: both occur, and the count is unchanged.

## Structure
- Package `zed64_chmem_pkg` holds:
  - the grant enum `G_NONE/G_VID/G_HOST`
  - the return-tag enum
  - the host entry struct
  - the default `AW`/`DW` constants
- Sub-module `chmem_hfifo`: synchronous FIFO with registered count and `full`/`empty`, asynchronous reset. Instantiated once.
- Arbiter, tag pipeline and counter stay in `chmem_arbiter`. Target size is about 200 lines.

## Test plan
- Video only: `vid_req` for 10 consecutive cycles, addresses 0..9, with RAM preloaded 8,5,12,12,15,23,15,18,12,4 → `vid_valid` on 10 consecutive cycles starting 3 cycles later, with the same data in order.
- Host idle path: write addr 0x10 = 0xA5 then read 0x10 with no video → `ram_we` pulse 2 cycles after acceptance; `host_rdata = 0xA5` with `host_rvalid` 4 cycles after the read was accepted.
- Contention: `vid_req` held 100 cycles while the host pushes 6 writes → `host_ready` drops after 4 accepts; `host_starve` rises after 64 cycles; all 4 writes are issued in order in the 4 cycles after `vid_req` falls; no video cycle is lost.
- Simultaneous: push and pop in the same cycle at count 2 → count stays 2; push attempt at full while popping → rejected (`host_ready` was 0).
- Reset mid-operation: assert `act_reset` with 3 FIFO entries and one host read in flight → all outputs 0 immediately; no `host_rvalid` afterwards; FIFO empty after release.
- Interleave: alternate `vid_req` 1/0 for 20 cycles with a host read queue → host reads complete only in gaps, and `vid_valid` spacing matches `vid_req` exactly.

Source files
------------

// File: rtl/zed64_chmem_pkg.sv
// Shared types and constants for the character-memory arbiter slice.
package zed64_chmem_pkg;

    localparam int CHMEM_AW = 11;
    localparam int CHMEM_DW = 8;

    // Width of the host starvation counter; it saturates rather than wraps.
    localparam int STARVE_CNT_W = 8;

    // Who owns the RAM port in a given cycle.
    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_VID  = 2'd1,
        G_HOST = 2'd2
    } grant_t;

    // Destination of the read data coming back from the RAM.
    typedef enum logic [1:0] {
        T_NONE = 2'd0,
        T_VID  = 2'd1,
        T_HRD  = 2'd2
    } rtag_t;

    // Host request as queued, at the default address/data widths.
    typedef struct packed {
        logic                we;
        logic [CHMEM_AW-1:0] addr;
        logic [CHMEM_DW-1:0] wdata;
    } host_entry_t;

    // Saturating increment used by the starvation counter.
    function automatic logic [STARVE_CNT_W-1:0] sat_inc8(input logic [STARVE_CNT_W-1:0] v);
        if (v == {STARVE_CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/chmem_hfifo.sv
// Small ordered FIFO for host requests. The head entry is presented
// combinationally so the arbiter can issue and pop it in the same cycle.
module chmem_hfifo
    import zed64_chmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1'b1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ZERO = (PW+1)'(1'b0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic [PW:0]   count_s;
    logic          empty_r;
    logic          full_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign dout  = mem_r[rd_ptr_r];
    assign empty = empty_r;
    assign full  = full_r;

    // Qualify push/pop against the current state and derive the next count.
    always_comb begin
        push_ok_s = push && !full_r;
        pop_ok_s  = pop && !empty_r;
        count_s   = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Pointers, count and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= CNT_ZERO;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_s;
            empty_r <= (count_s == CNT_ZERO);
            full_r  <= (count_s == CNT_FULL);
        end
    end

    // Entry storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/chmem_arbiter.sv
// Single-port character RAM arbiter: video fetch has absolute priority with
// fixed latency, host requests are queued and served in idle video cycles.
module chmem_arbiter
    import zed64_chmem_pkg::*;
#(
    parameter int AW         = CHMEM_AW,
    parameter int DW         = CHMEM_DW,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 64
) (
    input  logic          pixclk,
    input  logic          act_reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          host_starve,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int EW = 1 + AW + DW;
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM_C = STARVE_CNT_W'(STARVE_LIM);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } entry_t;

    entry_t  push_entry_s;
    entry_t  head_s;
    logic    push_s;
    logic    pop_s;
    logic    fifo_empty_s;
    logic    fifo_full_s;
    logic    live_r;
    grant_t  grant_s;

    logic          ram_en_s;
    logic          ram_we_s;
    logic [AW-1:0] ram_addr_s;
    logic [DW-1:0] ram_wdata_s;
    rtag_t         tag_s;

    logic          ram_en_r;
    logic          ram_we_r;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_wdata_r;
    rtag_t         tag_s1_r;
    rtag_t         tag_s2_r;

    logic          vid_valid_r;
    logic [DW-1:0] vid_data_r;
    logic          host_rvalid_r;
    logic [DW-1:0] host_rdata_r;

    logic [STARVE_CNT_W-1:0] cnt_r;
    logic [STARVE_CNT_W-1:0] cnt_s;
    logic                    starve_r;

    // host_ready comes from registers only, so a same-cycle pop never opens it.
    assign host_ready   = live_r && !fifo_full_s;
    assign push_s       = host_valid && host_ready;
    assign pop_s        = (grant_s == G_HOST);
    assign push_entry_s = '{we: host_we, addr: host_addr, wdata: host_wdata};

    chmem_hfifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_hfifo (
        .clk   (pixclk),
        .rst   (act_reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_entry_s),
        .dout  (head_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // Keeps host_ready low during reset and for the edge that releases it.
    always_ff @(posedge pixclk or posedge act_reset) begin
        if (act_reset) begin
            live_r <= 1'b0;
        end else begin
            live_r <= 1'b1;
        end
    end

    // Grant: video wins outright, otherwise drain the host queue.
    always_comb begin
        grant_s = G_NONE;
        if (vid_req) begin
            grant_s = G_VID;
        end else if (!fifo_empty_s) begin
            grant_s = G_HOST;
        end else begin
            grant_s = G_NONE;
        end
    end

    // Build the RAM command and return tag for the granted requester.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = ram_addr_r;
        ram_wdata_s = ram_wdata_r;
        tag_s       = T_NONE;
        case (grant_s)
            G_VID: begin
                ram_en_s   = 1'b1;
                ram_addr_s = vid_addr;
                tag_s      = T_VID;
            end
            G_HOST: begin
                ram_en_s    = 1'b1;
                ram_we_s    = head_s.we;
                ram_addr_s  = head_s.addr;
                ram_wdata_s = head_s.wdata;
                tag_s       = head_s.we ? T_NONE : T_HRD;
            end
            default: begin
                tag_s = T_NONE;
            end
        endcase
    end

    // Register the RAM command and advance the two-stage return tag.
    always_ff @(posedge pixclk or posedge act_reset) begin
        if (act_reset) begin
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {AW{1'b0}};
            ram_wdata_r <= {DW{1'b0}};
            tag_s1_r    <= T_NONE;
            tag_s2_r    <= T_NONE;
        end else begin
            ram_en_r    <= ram_en_s;
            ram_we_r    <= ram_we_s;
            ram_addr_r  <= ram_addr_s;
            ram_wdata_r <= ram_wdata_s;
            tag_s1_r    <= tag_s;
            tag_s2_r    <= tag_s1_r;
        end
    end

    // Steer returning read data to the requester recorded in the tag.
    always_ff @(posedge pixclk or posedge act_reset) begin
        if (act_reset) begin
            vid_valid_r   <= 1'b0;
            vid_data_r    <= {DW{1'b0}};
            host_rvalid_r <= 1'b0;
            host_rdata_r  <= {DW{1'b0}};
        end else begin
            vid_valid_r   <= 1'b0;
            host_rvalid_r <= 1'b0;
            case (tag_s2_r)
                T_VID: begin
                    vid_valid_r <= 1'b1;
                    vid_data_r  <= ram_rdata;
                end
                T_HRD: begin
                    host_rvalid_r <= 1'b1;
                    host_rdata_r  <= ram_rdata;
                end
                default: begin
                    vid_valid_r   <= 1'b0;
                    host_rvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Starvation count: grows while a queued head is blocked by video.
    always_comb begin
        cnt_s = cnt_r;
        if (fifo_empty_s || (grant_s == G_HOST)) begin
            cnt_s = {STARVE_CNT_W{1'b0}};
        end else if (grant_s == G_VID) begin
            cnt_s = sat_inc8(cnt_r);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Starvation counter and its status flag; status only, never preempts video.
    always_ff @(posedge pixclk or posedge act_reset) begin
        if (act_reset) begin
            cnt_r    <= {STARVE_CNT_W{1'b0}};
            starve_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_s;
            starve_r <= (cnt_s >= STARVE_LIM_C);
        end
    end

    assign ram_en      = ram_en_r;
    assign ram_we      = ram_we_r;
    assign ram_addr    = ram_addr_r;
    assign ram_wdata   = ram_wdata_r;
    assign vid_valid   = vid_valid_r;
    assign vid_data    = vid_data_r;
    assign host_rvalid = host_rvalid_r;
    assign host_rdata  = host_rdata_r;
    assign host_starve = starve_r;

endmodule

// File: tb/tb_chmem_arbiter.sv
// Scoreboard bench for chmem_arbiter with a behavioural synchronous RAM.
module tb_chmem_arbiter;

    localparam int HIST_N = 8192;

    logic        pixclk;
    logic        act_reset;
    logic        vid_req;
    logic [10:0] vid_addr;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [10:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic        host_starve;
    logic        ram_en;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    chmem_arbiter dut (
        .pixclk      (pixclk),
        .act_reset   (act_reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_valid   (vid_valid),
        .vid_data    (vid_data),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .host_starve (host_starve),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    typedef struct {int cyc; logic [7:0] data;} vexp_t;
    typedef struct {int cyc; logic [7:0] data; bit exact;} hexp_t;
    typedef struct {int cyc; logic [10:0] addr; logic [7:0] data;} wexp_t;

    vexp_t vq[$];
    hexp_t hq[$];
    wexp_t wq[$];

    logic [7:0]  ram_mem [2048];
    logic [7:0]  shadow  [2048];
    bit          vid_hist [HIST_N];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          host_exact = 1'b0;
    logic [10:0] rd_addrs [5];

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    always @(posedge pixclk) cyc <= cyc + 1;

    // Behavioural RAM: read data appears one cycle after ram_en.
    always @(posedge pixclk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ram"}, 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);
        check({tag, "_ret"}, 32'({vid_valid, vid_data, host_rvalid, host_rdata, host_starve, host_ready}), 32'd0);
    endtask

    // One cycle of stimulus; expected results are queued as requests are driven.
    task automatic step(input logic v, input logic [10:0] va, input logic hv, input logic hwe,
                        input logic [10:0] ha, input logic [7:0] hd, output logic acc);
        vid_req    = v;
        vid_addr   = va;
        host_valid = hv;
        host_we    = hwe;
        host_addr  = ha;
        host_wdata = hd;
        if (v) vq.push_back('{cyc + 3, shadow[va]});
        acc = hv && host_ready;
        if (acc) begin
            if (hwe) begin
                shadow[ha] = hd;
                wq.push_back('{(host_exact ? cyc + 2 : -1), ha, hd});
            end else begin
                hq.push_back('{cyc + 4, shadow[ha], host_exact});
            end
        end
        @(posedge pixclk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 8'd0, acc);
    endtask

    // Output monitor: pops the scoreboard as the DUT produces results.
    always @(negedge pixclk) begin
        vexp_t ve;
        hexp_t he;
        wexp_t we;
        if (!act_reset) begin
            if (cyc < HIST_N) vid_hist[cyc] = vid_req;
            if (vid_valid) begin
                if (vq.size() == 0) check("vid_spurious", 32'd1, 32'd0);
                else begin
                    ve = vq.pop_front();
                    check("vid_cyc", 32'(cyc), 32'(ve.cyc));
                    check("vid_data", 32'(vid_data), 32'(ve.data));
                end
            end else if (vq.size() > 0 && vq[0].cyc <= cyc) begin
                check("vid_missing", 32'd0, 32'd1);
                void'(vq.pop_front());
            end
            if (host_rvalid) begin
                if (hq.size() == 0) check("hrd_spurious", 32'd1, 32'd0);
                else begin
                    he = hq.pop_front();
                    if (he.exact) check("hrd_cyc", 32'(cyc), 32'(he.cyc));
                    else check("hrd_late", 32'(cyc >= he.cyc), 32'd1);
                    check("hrd_data", 32'(host_rdata), 32'(he.data));
                    if (cyc >= 3) check("hrd_gap", 32'(vid_hist[cyc - 3]), 32'd0);
                end
            end else if (hq.size() > 0 && hq[0].exact && hq[0].cyc <= cyc) begin
                check("hrd_missing", 32'd0, 32'd1);
                void'(hq.pop_front());
            end
            if (ram_en && ram_we) begin
                if (wq.size() == 0) check("wr_spurious", 32'd1, 32'd0);
                else begin
                    we = wq.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(we.addr));
                    check("wr_data", 32'(ram_wdata), 32'(we.data));
                    if (we.cyc >= 0) check("wr_cyc", 32'(cyc), 32'(we.cyc));
                    if (cyc >= 1) check("wr_gap", 32'(vid_hist[cyc - 1]), 32'd0);
                end
            end else if (wq.size() > 0 && wq[0].cyc >= 0 && wq[0].cyc <= cyc) begin
                check("wr_missing", 32'd0, 32'd1);
                void'(wq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   k;
        int   f;
        logic [7:0] pre [10];
        pre = '{8'd8, 8'd5, 8'd12, 8'd12, 8'd15, 8'd23, 8'd15, 8'd18, 8'd12, 8'd4};
        for (int i = 0; i < 2048; i++) begin
            ram_mem[i] = 8'd0;
            shadow[i]  = 8'd0;
        end
        for (int i = 0; i < 10; i++) begin
            ram_mem[i] = pre[i];
            shadow[i]  = pre[i];
        end
        rd_addrs = '{11'h010, 11'h040, 11'h041, 11'h042, 11'h043};
        act_reset  = 1'b1;
        vid_req    = 1'b0;
        vid_addr   = 11'd0;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = 11'd0;
        host_wdata = 8'd0;

        // Reset state and release
        repeat (3) @(posedge pixclk);
        #1;
        check_zero("reset");
        act_reset = 1'b0;
        check("rdy_at_release", 32'(host_ready), 32'd0);
        idle(1);
        check("rdy_after_release", 32'(host_ready), 32'd1);

        // Video only: ten back-to-back fetches
        for (int i = 0; i < 10; i++) step(1'b1, 11'(i), 1'b0, 1'b0, 11'd0, 8'd0, acc);
        idle(5);

        // Host write then read on an idle port, exact latency
        host_exact = 1'b1;
        step(1'b0, 11'd0, 1'b1, 1'b1, 11'h010, 8'hA5, acc);
        check("t2_acc_wr", 32'(acc), 32'd1);
        step(1'b0, 11'd0, 1'b1, 1'b0, 11'h010, 8'h00, acc);
        check("t2_acc_rd", 32'(acc), 32'd1);
        host_exact = 1'b0;
        idle(6);

        // Contention: video held 100 cycles while the host offers 6 writes
        k = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) check("t3_full", 32'(host_ready), 32'd0);
            if (i == 64) check("starve_lo", 32'(host_starve), 32'd0);
            if (i == 65) check("starve_hi", 32'(host_starve), 32'd1);
            step(1'b1, 11'(i % 10), (k < 6), 1'b1, 11'(11'h040 + k), 8'(8'h30 + k), acc);
            if (acc) k++;
        end
        check("t3_accepts", 32'(k), 32'd4);
        f = cyc;
        for (int j = 0; j < wq.size(); j++) wq[j].cyc = f + 1 + j;
        idle(1);
        check("starve_clr", 32'(host_starve), 32'd0);
        idle(6);

        // Simultaneous push/pop at count 2, then a push attempt at full
        step(1'b1, 11'd0, 1'b1, 1'b1, 11'h050, 8'h11, acc);
        check("t4_acc_a", 32'(acc), 32'd1);
        step(1'b1, 11'd1, 1'b1, 1'b1, 11'h051, 8'h12, acc);
        check("t4_acc_b", 32'(acc), 32'd1);
        step(1'b0, 11'd0, 1'b1, 1'b1, 11'h052, 8'h13, acc);
        check("t4_acc_pushpop", 32'(acc), 32'd1);
        step(1'b1, 11'd2, 1'b1, 1'b1, 11'h053, 8'h14, acc);
        check("t4_acc_d", 32'(acc), 32'd1);
        step(1'b1, 11'd3, 1'b1, 1'b1, 11'h054, 8'h15, acc);
        check("t4_acc_e", 32'(acc), 32'd1);
        check("t4_full", 32'(host_ready), 32'd0);
        step(1'b0, 11'd0, 1'b1, 1'b1, 11'h055, 8'h16, acc);
        check("t4_reject", 32'(acc), 32'd0);
        check("t4_rdy_back", 32'(host_ready), 32'd1);
        step(1'b1, 11'd4, 1'b0, 1'b0, 11'd0, 8'd0, acc);
        idle(8);

        // Reset with three queued writes and a host read in flight
        step(1'b1, 11'd5, 1'b1, 1'b0, 11'h010, 8'h00, acc);
        step(1'b1, 11'd6, 1'b1, 1'b1, 11'h060, 8'h21, acc);
        step(1'b1, 11'd7, 1'b1, 1'b1, 11'h061, 8'h22, acc);
        step(1'b0, 11'd0, 1'b1, 1'b1, 11'h062, 8'h23, acc);
        vid_req    = 1'b0;
        host_valid = 1'b0;
        act_reset  = 1'b1;
        vq.delete();
        hq.delete();
        wq.delete();
        #1;
        check_zero("t5_reset");
        repeat (2) @(posedge pixclk);
        #1;
        act_reset = 1'b0;
        check("t5_rdy_release", 32'(host_ready), 32'd0);
        idle(1);
        check("t5_rdy_up", 32'(host_ready), 32'd1);
        idle(8);

        // Interleave: alternating video with a queue of host reads
        k = 0;
        for (int i = 0; i < 20; i++) begin
            step((i % 2 == 0), 11'(i % 10), (k < 5), 1'b0, rd_addrs[k % 5], 8'd0, acc);
            if (acc) k++;
        end
        idle(8);
        check("t6_reads", 32'(k), 32'd5);

        idle(4);
        check("vq_left", 32'(vq.size()), 32'd0);
        check("hq_left", 32'(hq.size()), 32'd0);
        check("wq_left", 32'(wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
